// File: rtl/vic_midi_pkg.sv
// +--------------------------------------------------------------------+
// | vic_midi_pkg : shared constants and state encoding for MIDI blocks |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vic_midi_pkg;

    localparam int MIDI_BAUD      = 31250;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_TICK_DIV   = 2;

    // 6850-compatible bit positions in the status register
    localparam int STAT_RDRF = 0;
    localparam int STAT_FE   = 4;
    localparam int STAT_OVRN = 5;
    localparam int STAT_IRQ  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/midi_rx_reg.sv
// +--------------------------------------------------------------------+
// | midi_rx_reg : falling-edge holding register with load enable       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module midi_rx_reg #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_q;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q <= RESET;
        end else if (en_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

`default_nettype wire

// File: rtl/midi_rx.sv
// +--------------------------------------------------------------------+
// | midi_rx : 16x oversampled 8N1 MIDI receiver with 6850-style flags  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module midi_rx
    import vic_midi_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rxd,
    input  logic             rd_ack,
    input  logic             irq_en,
    output logic [WIDTH-1:0] data,
    output logic             rdrf,
    output logic             ovrn,
    output logic             fe,
    output logic             irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

    logic             sync1_q, rxs_q, rxs_prev_q;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    rx_state_e        state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             done_q, done_d;
    logic             stop_q, stop_d;
    logic             rdrf_q, rdrf_d;
    logic             ovrn_q, ovrn_d;
    logic             fe_q, fe_d;
    logic             load;

    // Synchroniser plus one history stage for start-edge detection
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            stop_q  <= 1'b1;
            rdrf_q  <= 1'b0;
            ovrn_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
            rdrf_q  <= rdrf_d;
            ovrn_q  <= ovrn_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        stop_d  = stop_q;
        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == HALF_LAST) begin
                        tcnt_d = '0;
                        bcnt_d = '0;
                        state_d = rxs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d  = '0;
                        shift_d = {rxs_q, shift_q[WIDTH-1:1]};
                        if (bcnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d  = '0;
                        done_d  = 1'b1;
                        stop_d  = rxs_q;
                        state_d = rxs_q ? ST_IDLE : ST_BREAK;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must go high before another start is accepted
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load = done_q && (!rdrf_q || rd_ack);

    always_comb begin
        rdrf_d = rdrf_q;
        ovrn_d = ovrn_q;
        fe_d   = fe_q;
        if (rd_ack && rdrf_q) begin
            rdrf_d = 1'b0;
            ovrn_d = 1'b0;
            fe_d   = 1'b0;
        end
        if (load) begin
            rdrf_d = 1'b1;
            fe_d   = !stop_q;
        end else if (done_q) begin
            ovrn_d = 1'b1;
        end
    end

    midi_rx_reg #(
        .WIDTH (WIDTH),
        .RESET ('0)
    ) u_data_reg (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (load),
        .d_i   (shift_q),
        .q_o   (data)
    );

    assign rdrf = rdrf_q;
    assign ovrn = ovrn_q;
    assign fe   = fe_q;
    assign irq  = irq_en && (rdrf_q || ovrn_q);

endmodule

`default_nettype wire

// File: tb/tb_midi_rx.sv
// +--------------------------------------------------------------------+
// | tb_midi_rx : directed self-checking bench for midi_rx              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_midi_rx;

    localparam int BITCLK = 32;   // clocks per bit: 16 ticks x 2 clocks

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       rxd    = 1'b1;
    logic       rd_ack = 1'b0;
    logic       irq_en = 1'b0;
    logic [7:0] data;
    logic       rdrf, ovrn, fe, irq;

    int n_cmp   = 0;
    int n_err   = 0;
    int neg_cnt = 0;

    midi_rx #(
        .WIDTH      (8),
        .OVERSAMPLE (16),
        .TICK_DIV   (2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .rxd    (rxd),
        .rd_ack (rd_ack),
        .irq_en (irq_en),
        .data   (data),
        .rdrf   (rdrf),
        .ovrn   (ovrn),
        .fe     (fe),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    // Falling edges since reset release; prescaler wraps on even counts
    always @(negedge clock) begin
        if (reset) neg_cnt <= 0;
        else       neg_cnt <= neg_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Edge on which the completed byte lands, given the edge count at the start edge
    function automatic int comp_edge(input int k0);
        int n3;
        n3 = k0 + 3;
        return (n3 % 2 == 0) ? n3 + 305 : n3 + 304;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BITCLK) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BITCLK) @(posedge clock);
        end
        rxd = stop;
        repeat (BITCLK) @(posedge clock);
    endtask

    task automatic pulse_ack();
        @(posedge clock);
        rd_ack = 1'b1;
        @(posedge clock);
        rd_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        irq_en = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {rdrf, ovrn, fe}); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        @(posedge clock);
        reset = 1'b0;
        repeat (BITCLK) @(posedge clock);
    endtask

    task automatic test_basic();
        int c;
        @(posedge clock);
        c = comp_edge(neg_cnt);
        fork
            send_frame(8'h90, 1'b1);
            begin
                while (neg_cnt < c - 1) @(posedge clock);
                #1;
                n_cmp++; if (rdrf !== 1'b0) begin n_err++; $display("FAIL basic_early_rdrf: got %b want 0", rdrf); end
                @(posedge clock);
                #1;
                n_cmp++; if (rdrf !== 1'b1) begin n_err++; $display("FAIL basic_latency_rdrf: got %b want 1", rdrf); end
                n_cmp++; if (data !== 8'h90) begin n_err++; $display("FAIL basic_latency_data: got %h want 90", data); end
            end
        join
        rxd = 1'b1;
        #1;
        n_cmp++; if ({ovrn, fe} !== 2'b00) begin n_err++; $display("FAIL basic_ovrn_fe: got %b want 00", {ovrn, fe}); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL basic_irq_en1: got %b want 1", irq); end
        irq_en = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_irq_en0: got %b want 0", irq); end
        irq_en = 1'b1;
    endtask

    task automatic test_ack_then_next();
        pulse_ack();
        n_cmp++; if ({rdrf, irq} !== 2'b00) begin n_err++; $display("FAIL ack_clear: rdrf,irq got %b want 00", {rdrf, irq}); end
        @(posedge clock);
        send_frame(8'h3C, 1'b1);
        rxd = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h3C) begin n_err++; $display("FAIL next_data: got %h want 3c", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b100) begin n_err++; $display("FAIL next_flags: got %b want 100", {rdrf, ovrn, fe}); end
    endtask

    task automatic test_overrun();
        pulse_ack();
        @(posedge clock);
        send_frame(8'h45, 1'b1);
        send_frame(8'h7F, 1'b1);
        rxd = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h45) begin n_err++; $display("FAIL ovr_data: got %h want 45", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b110) begin n_err++; $display("FAIL ovr_flags: got %b want 110", {rdrf, ovrn, fe}); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovr_irq: got %b want 1", irq); end
        repeat (BITCLK) @(posedge clock);
        pulse_ack();
        n_cmp++; if ({rdrf, ovrn, irq} !== 3'b000) begin n_err++; $display("FAIL ovr_ack: rdrf,ovrn,irq got %b want 000", {rdrf, ovrn, irq}); end
    endtask

    task automatic test_break();
        @(posedge clock);
        send_frame(8'hA5, 1'b0);
        repeat (3 * BITCLK) @(posedge clock);
        #1;
        n_cmp++; if (data !== 8'hA5) begin n_err++; $display("FAIL brk_data: got %h want a5", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b101) begin n_err++; $display("FAIL brk_flags: got %b want 101", {rdrf, ovrn, fe}); end
        rxd = 1'b1;
        repeat (2 * BITCLK) @(posedge clock);
        #1;
        n_cmp++; if ({rdrf, ovrn} !== 2'b10) begin n_err++; $display("FAIL brk_no_retrigger: rdrf,ovrn got %b want 10", {rdrf, ovrn}); end
        pulse_ack();
        n_cmp++; if ({rdrf, fe} !== 2'b00) begin n_err++; $display("FAIL brk_ack: rdrf,fe got %b want 00", {rdrf, fe}); end
        @(posedge clock);
        send_frame(8'h12, 1'b1);
        rxd = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h12) begin n_err++; $display("FAIL brk_next_data: got %h want 12", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b100) begin n_err++; $display("FAIL brk_next_flags: got %b want 100", {rdrf, ovrn, fe}); end
    endtask

    task automatic test_glitch();
        pulse_ack();
        @(posedge clock);
        rxd = 1'b0;
        repeat (6) @(posedge clock);
        rxd = 1'b1;
        repeat (2 * BITCLK) @(posedge clock);
        #1;
        n_cmp++; if ({rdrf, ovrn, fe, irq} !== 4'b0000) begin n_err++; $display("FAIL glitch_flags: got %b want 0000", {rdrf, ovrn, fe, irq}); end
        n_cmp++; if (data !== 8'h12) begin n_err++; $display("FAIL glitch_data: got %h want 12", data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h55;
        @(posedge clock);
        rxd = 1'b0;
        repeat (BITCLK) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            repeat (BITCLK) @(posedge clock);
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", data); end
        n_cmp++; if ({rdrf, ovrn, fe, irq} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags: got %b want 0000", {rdrf, ovrn, fe, irq}); end
        rxd = 1'b1;
        repeat (3) @(posedge clock);
        reset = 1'b0;
        repeat (BITCLK) @(posedge clock);
        send_frame(8'h55, 1'b1);
        rxd = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h55) begin n_err++; $display("FAIL rstmid_next_data: got %h want 55", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b100) begin n_err++; $display("FAIL rstmid_next_flags: got %b want 100", {rdrf, ovrn, fe}); end
    endtask

    task automatic test_ack_same_clock();
        int c;
        @(posedge clock);
        c = comp_edge(neg_cnt);
        fork
            send_frame(8'h66, 1'b1);
            begin
                while (neg_cnt < c - 1) @(posedge clock);
                rd_ack = 1'b1;
                @(posedge clock);
                rd_ack = 1'b0;
            end
        join
        rxd = 1'b1;
        #1;
        n_cmp++; if (data !== 8'h66) begin n_err++; $display("FAIL same_clk_data: got %h want 66", data); end
        n_cmp++; if ({rdrf, ovrn, fe} !== 3'b100) begin n_err++; $display("FAIL same_clk_flags: got %b want 100", {rdrf, ovrn, fe}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_then_next();
        test_overrun();
        test_break();
        test_glitch();
        test_reset_mid();
        test_ack_same_clock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
